reg_bank_param: RTL and testbench
=================================

Name: reg_bank_param

Overview:
Parametrised successor to the CPU register bank: a 2^ADDR_W x DATA_W register file with two registered ALU read ports, one debug read port, and three write sources (general, PC, status flags).
- After reset it clears itself one register per cycle through an init state machine, so no large async-reset array is needed.
- Simultaneous general and PC/SR writes to different registers both commit, with defined priority on conflicts.
- Sits between control unit, ALU and program counter.

Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, register index width; NREGS = 2**ADDR_W
- PC_IDX, 0, index of program counter register
- SR_IDX, 2, index of status register

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- src_reg  in  ADDR_W  index driven to a
- dst_reg  in  ADDR_W  index driven to b
- wr_en  in  1  general write strobe
- wr_reg  in  ADDR_W  general write index
- wr_data  in  DATA_W  general write data
- pc_inc  in  1  PC update strobe
- pc_data_in  in  DATA_W  new PC value
- sr_wr_en  in  1  flag update strobe from ALU
- sr_data_in  in  DATA_W  new SR value
- dbg_sel  in  ADDR_W  debug/user read index
- a  out  DATA_W  registered read of src_reg
- b  out  DATA_W  registered read of dst_reg
- pc_data_out  out  DATA_W  registered read of PC_IDX
- dbg_out  out  DATA_W  registered read of dbg_sel
- ready  out  1  high when bank is in RUN

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- While rst is high:
  - state=INIT, init_cnt=0.
  - a, b, pc_data_out, dbg_out = 0; ready = 0.
  - Array contents are not reset directly.
- INIT state:
  - Each clk edge writes 0 to regmem[init_cnt], then init_cnt increments.
  - On the edge that writes index NREGS-1, state goes to RUN and ready rises on that edge.
  - INIT therefore lasts exactly NREGS cycles after rst deassertion.
  - All write strobes are ignored during INIT; outputs hold 0.
- RUN state, per clk edge:
  - Reads: a, b, pc_data_out, dbg_out are loaded from the array at the indices present at that edge. Latency is 1 cycle from index to output.
  - Writes are evaluated independently per target register.
  - General write: if wr_en, regmem[wr_reg] <= wr_data.
  - PC write: if pc_inc and not (wr_en and wr_reg==PC_IDX), regmem[PC_IDX] <= pc_data_in. The general write wins on conflict.
  - SR write: if sr_wr_en and not (wr_en and wr_reg==SR_IDX), regmem[SR_IDX] <= sr_data_in. The general write wins on conflict.
  - wr_en to a register other than PC_IDX together with pc_inc: both commit in the same cycle.
  - No write source modifies a register other than its target.
- Widths: all data paths are DATA_W with no extension or truncation. Indices are full ADDR_W, so every index is valid and there is no out-of-range case.
- Reset mid-operation (INIT or RUN):
  - Outputs are forced to 0 immediately, asynchronously.
  - The FSM returns to INIT with init_cnt=0.
  - A full NREGS-cycle clear repeats after release.
- FSM has two states only (INIT, RUN); there is no other exit from RUN except rst.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN
- Defined (write-first bypass): if a write commits to index X on the same edge a read port samples X, that port's output gets the newly written value. The value is resolved with the same priority as the write (general > PC/SR).
- Undefined (read-old): the port outputs the pre-write array contents; the new value is visible from the next read.
- Both modes apply identically to a, b, pc_data_out and dbg_out. INIT behaviour is unaffected.

Test Plan:
- Reset and init: pulse rst for 3 cycles then release, DATA_W=16, ADDR_W=4 -> ready stays 0 for 15 edges and rises on the 16th; a read of every index through dbg_sel then returns 0x0000.
- General write and read latency: in RUN, write r5=0x1234; next cycle src_reg=5 -> a=0x1234 one edge after sampling; b is unaffected.
- Dual commit: wr_en r4=0xAAAA together with pc_inc, pc_data_in=0x0102 -> r4=0xAAAA, pc_data_out=0x0102 on the following read.
- Conflict priority:
  - wr_en r0=0x5555 with pc_inc 0x0002 -> PC=0x5555.
  - wr_en r2=0x00F0 with sr_wr_en 0x000F -> SR=0x00F0.
- Bypass: r7 holds 0x0000; write r7=0xBEEF with src_reg=7 on the same edge -> a=0xBEEF with REG_BANK_BYPASS_EN, a=0x0000 without it. The next read returns 0xBEEF in both modes.
- Reset mid-init and mid-run:
  - Assert rst 5 cycles into INIT -> ready=0, outputs 0 immediately; after release, 16 full init cycles occur.
  - Assert rst during RUN with r9=0x1111 -> after re-init, r9 reads 0x0000.

Source files
------------

// File: rtl/reg_bank_param_if.sv
// Bus bundle between the register bank (slave) and the control unit / ALU / PC side (master).
// Carries read indices, the three write sources and the registered read results.
interface reg_bank_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_reg;
  logic [DATA_W-1:0] wr_data;
  logic              pc_inc;
  logic [DATA_W-1:0] pc_data_in;
  logic              sr_wr_en;
  logic [DATA_W-1:0] sr_data_in;
  logic [ADDR_W-1:0] dbg_sel;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] pc_data_out;
  logic [DATA_W-1:0] dbg_out;
  logic              ready;

  modport master (
    output src_reg, dst_reg, wr_en, wr_reg, wr_data,
    output pc_inc, pc_data_in, sr_wr_en, sr_data_in, dbg_sel,
    input  a, b, pc_data_out, dbg_out, ready
  );

  modport slave (
    input  src_reg, dst_reg, wr_en, wr_reg, wr_data,
    input  pc_inc, pc_data_in, sr_wr_en, sr_data_in, dbg_sel,
    output a, b, pc_data_out, dbg_out, ready
  );
endinterface

// File: rtl/reg_bank_param.sv
// 2**ADDR_W x DATA_W register bank: self-clearing after reset, four registered read ports, three write sources.
// Define REG_BANK_BYPASS_EN for write-first read ports; otherwise reads return pre-write contents.
module reg_bank_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 0,
  parameter int SR_IDX = 2
) (
  input logic              clk,
  input logic              rst,
  reg_bank_param_if.slave  bus
);
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int NPORTS = 4;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] init_cnt_reg, init_cnt_next;
  logic              init_we;
  logic              run_en;

  logic [DATA_W-1:0] regmem [NREGS];
  logic [NREGS-1:0]  wr_hit;
  logic [DATA_W-1:0] wr_val [NREGS];

  logic [ADDR_W-1:0] rd_idx  [NPORTS];
  logic [DATA_W-1:0] rd_next [NPORTS];
  logic [DATA_W-1:0] rd_q    [NPORTS];

  // ---------------- init / run FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      ST_INIT: begin
        init_cnt_next = init_cnt_reg + ADDR_W'(1);
        if (init_cnt_reg == '1) state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  always_comb begin
    init_we = 1'b0;
    run_en  = 1'b0;
    case (state_reg)
      ST_INIT: init_we = 1'b1;
      ST_RUN:  run_en  = 1'b1;
      default: init_we = 1'b0;
    endcase
  end

  assign bus.ready = run_en;

  // ---------------- storage: one register per index ----------------
  // Each register resolves its own write: general write beats PC/SR strobes.
  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
      localparam bit IS_PC = (gi == PC_IDX);
      localparam bit IS_SR = (gi == SR_IDX);

      logic              gen_hit;
      logic              pc_hit;
      logic              sr_hit;
      logic [DATA_W-1:0] q_reg;

      assign gen_hit = bus.wr_en && (bus.wr_reg == ADDR_W'(gi));
      assign pc_hit  = IS_PC && bus.pc_inc;
      assign sr_hit  = IS_SR && bus.sr_wr_en;

      assign wr_hit[gi] = run_en && (gen_hit || pc_hit || sr_hit);
      assign wr_val[gi] = gen_hit ? bus.wr_data    :
                          pc_hit  ? bus.pc_data_in :
                                    bus.sr_data_in;

      // No reset on the array itself; the INIT sweep clears it.
      always_ff @(posedge clk) begin
        if (init_we && (init_cnt_reg == ADDR_W'(gi))) begin
          q_reg <= '0;
        end else if (wr_hit[gi]) begin
          q_reg <= wr_val[gi];
        end
      end

      assign regmem[gi] = q_reg;
    end
  endgenerate

  // ---------------- registered read ports ----------------
  assign rd_idx[0] = bus.src_reg;
  assign rd_idx[1] = bus.dst_reg;
  assign rd_idx[2] = ADDR_W'(PC_IDX);
  assign rd_idx[3] = bus.dbg_sel;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
      logic [DATA_W-1:0] q_reg;

`ifdef REG_BANK_BYPASS_EN
      assign rd_next[gi] = wr_hit[rd_idx[gi]] ? wr_val[rd_idx[gi]] : regmem[rd_idx[gi]];
`else
      assign rd_next[gi] = regmem[rd_idx[gi]];
`endif

      // Outputs read as zero until the bank reaches RUN.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= '0;
        end else if (run_en) begin
          q_reg <= rd_next[gi];
        end else begin
          q_reg <= '0;
        end
      end

      assign rd_q[gi] = q_reg;
    end
  endgenerate

  assign bus.a           = rd_q[0];
  assign bus.b           = rd_q[1];
  assign bus.pc_data_out = rd_q[2];
  assign bus.dbg_out     = rd_q[3];

endmodule

// File: tb/tb_reg_bank_param.sv
// Randomised self-checking bench for reg_bank_param against an array-based reference model.
// Build with REG_BANK_BYPASS_EN defined to check write-first read ports.
module tb_reg_bank_param;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;
  localparam int PC = 0;
  localparam int SR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_bank_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_bank_param #(.DATA_W(DW), .ADDR_W(AW), .PC_IDX(PC), .SR_IDX(SR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_a, exp_b, exp_pc, exp_dbg;

  // One clock of stimulus; starts and ends on a falling edge.
  task automatic step(input logic [AW-1:0] s, input logic [AW-1:0] d,
                      input logic we, input logic [AW-1:0] wr, input logic [DW-1:0] wd,
                      input logic pi, input logic [DW-1:0] pd,
                      input logic sw, input logic [DW-1:0] sd,
                      input logic [AW-1:0] ds);
    logic [DW-1:0] nxt [NR];
    bus.src_reg = s;   bus.dst_reg = d;   bus.dbg_sel = ds;
    bus.wr_en = we;    bus.wr_reg = wr;   bus.wr_data = wd;
    bus.pc_inc = pi;   bus.pc_data_in = pd;
    bus.sr_wr_en = sw; bus.sr_data_in = sd;
    nxt = model;
    if (pi) nxt[PC] = pd;
    if (sw) nxt[SR] = sd;
    if (we) nxt[wr] = wd;
`ifdef REG_BANK_BYPASS_EN
    exp_a = nxt[s]; exp_b = nxt[d]; exp_pc = nxt[PC]; exp_dbg = nxt[ds];
`else
    exp_a = model[s]; exp_b = model[d]; exp_pc = model[PC]; exp_dbg = model[ds];
`endif
    model = nxt;
    @(posedge clk);
    @(negedge clk);
    bus.wr_en = 1'b0; bus.pc_inc = 1'b0; bus.sr_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] ds);
    step(s, d, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, ds);
  endtask

  // Counts rising edges after release until ready is seen (bounded).
  task automatic wait_init(output int edges);
    edges = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        edges = k;
        break;
      end
    end
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic test_reset;
    int edges;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || bus.a !== '0 || bus.b !== '0 || bus.pc_data_out !== '0 || bus.dbg_out !== '0) begin
      $display("FAIL reset_outputs ready=%b a=%h b=%h pc=%h dbg=%h want all 0",
               bus.ready, bus.a, bus.b, bus.pc_data_out, bus.dbg_out);
      errors++;
    end
    rst = 1'b0;
    wait_init(edges);
    checks++;
    if (edges !== 16) begin
      $display("FAIL init_length ready after %0d edges want 16", edges);
      errors++;
    end
    for (int i = 0; i < NR; i++) begin
      rd(AW'(i), AW'(i), AW'(i));
      checks++;
      if (bus.dbg_out !== 16'h0000) begin
        $display("FAIL init_clear r%0d dbg_out=%h want 0000", i, bus.dbg_out);
        errors++;
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write_latency;
    step(4'd3, 4'd6, 1'b1, 4'd5, 16'h1234, 1'b0, '0, 1'b0, '0, 4'd1);
    rd(4'd5, 4'd6, 4'd5);
    checks++;
    if (bus.a !== 16'h1234) begin
      $display("FAIL write_latency a=%h want 1234", bus.a);
      errors++;
    end
    checks++;
    if (bus.b !== exp_b) begin
      $display("FAIL write_latency_b b=%h want %h", bus.b, exp_b);
      errors++;
    end
    $display("test_write_latency done");
  endtask

  task automatic test_dual_commit;
    step(4'd1, 4'd1, 1'b1, 4'd4, 16'hAAAA, 1'b1, 16'h0102, 1'b0, '0, 4'd1);
    rd(4'd4, 4'd1, 4'd4);
    checks++;
    if (bus.a !== 16'hAAAA) begin
      $display("FAIL dual_commit_r4 a=%h want aaaa", bus.a);
      errors++;
    end
    checks++;
    if (bus.pc_data_out !== 16'h0102) begin
      $display("FAIL dual_commit_pc pc=%h want 0102", bus.pc_data_out);
      errors++;
    end
    $display("test_dual_commit done");
  endtask

  task automatic test_conflict;
    step(4'd1, 4'd1, 1'b1, 4'd0, 16'h5555, 1'b1, 16'h0002, 1'b0, '0, 4'd1);
    rd(4'd1, 4'd1, 4'd1);
    checks++;
    if (bus.pc_data_out !== 16'h5555) begin
      $display("FAIL conflict_pc pc=%h want 5555", bus.pc_data_out);
      errors++;
    end
    step(4'd1, 4'd1, 1'b1, 4'd2, 16'h00F0, 1'b0, '0, 1'b1, 16'h000F, 4'd1);
    rd(4'd2, 4'd1, 4'd2);
    checks++;
    if (bus.a !== 16'h00F0 || bus.dbg_out !== 16'h00F0) begin
      $display("FAIL conflict_sr a=%h dbg=%h want 00f0", bus.a, bus.dbg_out);
      errors++;
    end
    $display("test_conflict done");
  endtask

  task automatic test_bypass;
    step(4'd7, 4'd7, 1'b1, 4'd7, 16'hBEEF, 1'b0, '0, 1'b0, '0, 4'd7);
    checks++;
`ifdef REG_BANK_BYPASS_EN
    if (bus.a !== 16'hBEEF || bus.dbg_out !== 16'hBEEF) begin
      $display("FAIL bypass_same_edge a=%h dbg=%h want beef", bus.a, bus.dbg_out);
      errors++;
    end
`else
    if (bus.a !== 16'h0000 || bus.dbg_out !== 16'h0000) begin
      $display("FAIL bypass_same_edge a=%h dbg=%h want 0000", bus.a, bus.dbg_out);
      errors++;
    end
`endif
    rd(4'd7, 4'd7, 4'd7);
    checks++;
    if (bus.a !== 16'hBEEF) begin
      $display("FAIL bypass_next_read a=%h want beef", bus.a);
      errors++;
    end
    $display("test_bypass done");
  endtask

  task automatic test_random;
    for (int n = 0; n < 300; n++) begin
      step(AW'($urandom_range(0, NR-1)), AW'($urandom_range(0, NR-1)),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, NR-1)), DW'($urandom),
           1'($urandom_range(0, 1)), DW'($urandom),
           1'($urandom_range(0, 1)), DW'($urandom),
           AW'($urandom_range(0, NR-1)));
      checks++;
      if (bus.a !== exp_a || bus.b !== exp_b || bus.pc_data_out !== exp_pc || bus.dbg_out !== exp_dbg) begin
        $display("FAIL random_%0d got a=%h b=%h pc=%h dbg=%h want a=%h b=%h pc=%h dbg=%h",
                 n, bus.a, bus.b, bus.pc_data_out, bus.dbg_out, exp_a, exp_b, exp_pc, exp_dbg);
        errors++;
      end
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid_init;
    int edges;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.a !== '0 || bus.dbg_out !== '0) begin
      $display("FAIL mid_init_reset ready=%b a=%h dbg=%h want 0", bus.ready, bus.a, bus.dbg_out);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_init(edges);
    checks++;
    if (edges !== 16) begin
      $display("FAIL mid_init_length ready after %0d edges want 16", edges);
      errors++;
    end
    $display("test_reset_mid_init done");
  endtask

  task automatic test_reset_mid_run;
    int edges;
    step(4'd1, 4'd1, 1'b1, 4'd9, 16'h1111, 1'b1, 16'h0042, 1'b0, '0, 4'd9);
    rd(4'd9, 4'd9, 4'd9);
    checks++;
    if (bus.a !== 16'h1111) begin
      $display("FAIL mid_run_pre a=%h want 1111", bus.a);
      errors++;
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0 || bus.a !== '0 || bus.b !== '0 || bus.pc_data_out !== '0 || bus.dbg_out !== '0) begin
      $display("FAIL mid_run_async ready=%b a=%h b=%h pc=%h dbg=%h want 0",
               bus.ready, bus.a, bus.b, bus.pc_data_out, bus.dbg_out);
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_init(edges);
    checks++;
    if (edges !== 16) begin
      $display("FAIL mid_run_init_length ready after %0d edges want 16", edges);
      errors++;
    end
    rd(4'd9, 4'd9, 4'd9);
    checks++;
    if (bus.a !== 16'h0000 || bus.pc_data_out !== 16'h0000) begin
      $display("FAIL mid_run_cleared a=%h pc=%h want 0000", bus.a, bus.pc_data_out);
      errors++;
    end
    $display("test_reset_mid_run done");
  endtask

  initial begin
    bus.src_reg = '0; bus.dst_reg = '0; bus.dbg_sel = '0;
    bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    bus.pc_inc = 1'b0; bus.pc_data_in = '0;
    bus.sr_wr_en = 1'b0; bus.sr_data_in = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    test_reset;
    test_write_latency;
    test_dual_commit;
    test_conflict;
    test_bypass;
    test_random;
    test_reset_mid_init;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
